key_chain_loader: RTL and testbench
===================================

# key_chain_loader

Serial key/configuration receiver for locked designs. Hunts a sync byte on a single-bit strobed input, then shifts in a KEY_W-bit key LSB first and checks one even-parity bit. It presents the key in parallel to the redacted submodule instances with a valid/ack handshake. It is the receiving end of the serial key chain the test tops drive, and it sits between the top-level key pin and the locked submodules.

## Interface
- KEY_W, 32: key width in bits, 2..1024.
- SYNC, 8'hA5: 8-bit frame sync pattern; its first-received bit is the MSB.
- TIMEOUT, 255: maximum idle cycles between strobes inside a frame, 1..65535.
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sin  in  1  serial data bit.
- sin_valid  in  1  bit strobe; sin is sampled only on cycles where it is high.
- key_out  out  KEY_W  last accepted key; bit 0 is the first data bit received.
- key_valid  out  1  high while a freshly accepted key awaits ack.
- key_ack  in  1  consumer acknowledge.
- err  out  1  one-cycle pulse on parity failure or timeout.

## Operation
- Reset values:
  - state IDLE; key_out 0; key_valid 0; err 0.
  - Sync shift register, bit counter, gap counter and shadow register all 0.
- IDLE:
  - On each strobe: sync_sr <= {sync_sr[6:0], sin}.
  - If that new value equals SYNC: move to DATA, clear the bit counter and the gap counter.
  - sync_sr is cleared whenever IDLE is entered.
- DATA:
  - On each strobe: shadow[cnt] <= sin, cnt <= cnt + 1.
  - The strobe with cnt == KEY_W-1 moves to PARITY.
  - cnt width is clog2(KEY_W); it never wraps within a frame.
- PARITY, on a strobe:
  - Expected parity is sin == ^shadow, so the total count of ones over data plus parity is even.
  - Match: key_out <= shadow, key_valid <= 1, move to HOLD.
  - Mismatch: err <= 1 for exactly one cycle, move to IDLE, key_out unchanged.
- HOLD:
  - sin/sin_valid are ignored.
  - On key_ack: key_valid <= 0, move to IDLE.
  - key_out holds its value until the next accepted frame.
- Gap timeout (DATA and PARITY only):
  - The gap counter increments each cycle without a strobe and clears on each strobe.
  - Reaching TIMEOUT: err pulse, move to IDLE, shadow discarded, key_out unchanged.
  - If a strobe and the terminal count fall in the same cycle, the strobe wins and no timeout occurs.
- Sync-shaped data inside DATA is treated as data; there is no resync mid-frame.
- key_ack outside HOLD is ignored.
- Reset mid-frame or in HOLD: immediate return to reset values, including key_out and key_valid.

## Timing
- All outputs are registered.
- key_valid and the new key_out appear on the edge that samples the parity strobe, i.e. visible the cycle after that strobe.
- The earliest next-frame sync bit is sampled one cycle after the ack cycle. Minimum frame length is 8+KEY_W+1 strobes.
- err rises on the edge that samples the bad parity bit (or on the timeout edge) and falls on the next edge.
- key_valid falls on the edge that samples key_ack. Ack held high for multiple cycles has no further effect.
- Strobes may arrive every cycle; back-to-back frames are lost only while in HOLD.

## Test plan
- Send sync A5 (10100101), then data 0xDEADBEEF LSB first, then parity 0, all with continuous strobes -> key_valid=1 and key_out=32'hDEADBEEF one cycle after the parity strobe; err stays 0.
- Same frame with parity 1 -> one-cycle err pulse; key_valid stays 0; key_out keeps its previous value (0 after reset).
- Leading noise bits 1,1,0 before A5, and strobes gapped with 3 idle cycles each -> correct key accepted; idle cycles do not advance the FSM.
- Strobes stop for 255 cycles after 10 data bits -> err pulse on the 255th idle cycle, state IDLE. A following valid frame carrying 0x12345678 (parity 1) is accepted.
- Hold key_ack low for 20 cycles while streaming a second frame -> key_valid stays high, key_out unchanged. After the ack, key_valid=0 and a fresh frame is accepted.
- Assert rst during data bit 16 of a frame, then release it -> all outputs 0 immediately. The next full frame loads correctly.

Source files
------------

// File: rtl/key_chain_loader.sv
// Serial key receiver: hunts a sync byte, shifts in a KEY_W-bit key LSB first,
// checks even parity and presents the key with a valid/ack handshake.
module key_chain_loader #(
    parameter int unsigned KEY_W   = 32,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(KEY_W);
    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, HOLD} state_t;

    state_t             state, state_nxt;
    logic [7:0]         sync_sr, sync_nxt;
    logic [KEY_W-1:0]   shadow, shadow_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap, gap_nxt;
    logic [KEY_W-1:0]   key_nxt;
    logic               valid_nxt;
    logic               err_nxt;
    logic               to_idle;
    logic [7:0]         sync_word;

    assign sync_word = {sync_sr[6:0], sin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sync_sr   <= '0;
            shadow    <= '0;
            cnt       <= '0;
            gap       <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync_sr   <= sync_nxt;
            shadow    <= shadow_nxt;
            cnt       <= cnt_nxt;
            gap       <= gap_nxt;
            key_out   <= key_nxt;
            key_valid <= valid_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sync_nxt   = sync_sr;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        gap_nxt    = gap;
        key_nxt    = key_out;
        valid_nxt  = key_valid;
        err_nxt    = 1'b0;
        to_idle    = 1'b0;

        case (state)
            IDLE: begin
                if (sin_valid) begin
                    sync_nxt = sync_word;
                    if (sync_word == SYNC) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        gap_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (sin_valid) begin
                    shadow_nxt[cnt] = sin;
                    gap_nxt         = '0;
                    if (cnt == LAST_BIT) begin
                        state_nxt = PARITY;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (gap == GAP_LAST) begin
                    err_nxt = 1'b1;
                    to_idle = 1'b1;
                end else begin
                    gap_nxt = gap + 1'b1;
                end
            end
            PARITY: begin
                // Parity bit makes the total count of ones over data plus parity even
                if (sin_valid) begin
                    gap_nxt = '0;
                    if (sin == ^shadow) begin
                        key_nxt   = shadow;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        err_nxt = 1'b1;
                        to_idle = 1'b1;
                    end
                end else if (gap == GAP_LAST) begin
                    err_nxt = 1'b1;
                    to_idle = 1'b1;
                end else begin
                    gap_nxt = gap + 1'b1;
                end
            end
            HOLD: begin
                if (key_ack) begin
                    valid_nxt = 1'b0;
                    to_idle   = 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        // Every return to IDLE restarts the sync hunt from a clean slate
        if (to_idle) begin
            state_nxt  = IDLE;
            sync_nxt   = '0;
            shadow_nxt = '0;
            cnt_nxt    = '0;
            gap_nxt    = '0;
        end
    end

endmodule

// File: tb/tb_key_chain_loader.sv
// Scoreboard bench for key_chain_loader: stimulus queues expected key/err events,
// a negedge monitor pops and checks them against what the DUT presents.
module tb_key_chain_loader;

    logic        clk;
    logic        rst;
    logic        sin;
    logic        sin_valid;
    logic [31:0] key_out;
    logic        key_valid;
    logic        key_ack;
    logic        err;

    typedef struct {
        bit          kind;   // 0 = key accepted, 1 = err pulse
        logic [31:0] key;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;

    key_chain_loader #(.KEY_W(32), .SYNC(8'hA5), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input bit kind);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: output at cycle %0d with nothing expected",
                     kind ? "err" : "key", cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == 1'b0 && key_out !== e.key)) begin
                errors++;
                $display("FAIL event: got kind=%0d key=%h cycle=%0d, expected kind=%0d key=%h cycle=%0d",
                         kind, key_out, cyc, e.kind, e.key, e.cyc);
            end
        end
    endtask

    // Monitor: a key_valid rising edge or an err-high cycle consumes one expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (key_valid && !prev_v) observe(1'b0);
                if (err) observe(1'b1);
            end
            prev_v = key_valid;
        end
    end

    task automatic push(input bit kind, input logic [31:0] key, input int at);
        exp_t e;
        e.kind = kind;
        e.key  = key;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int gap);
        sin       = b;
        sin_valid = 1'b1;
        last_cyc  = cyc;
        @(negedge clk);
        sin_valid = 1'b0;
        sin       = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_sync(input int gap);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(s[i], gap);
    endtask

    task automatic send_data(input logic [31:0] k, input int n, input int gap);
        for (int i = 0; i < n; i++) send_bit(k[i], gap);
    endtask

    task automatic send_frame(input logic [31:0] k, input logic par, input bit good, input int gap);
        send_sync(gap);
        send_data(k, 32, gap);
        push(good ? 1'b0 : 1'b1, k, cyc + 1);
        send_bit(par, gap);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs still pending after %0d cycles, expected 0",
                     q.size(), budget);
            q.delete();
        end
    endtask

    task automatic do_ack(input int len);
        key_ack = 1'b1;
        repeat (len) @(negedge clk);
        key_ack = 1'b0;
        chk("valid_after_ack", {31'd0, key_valid}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; key_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_key_out", key_out, 32'd0);
        chk("reset_key_valid", {31'd0, key_valid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Bad parity: err pulse, nothing loaded
        send_frame(32'hDEADBEEF, 1'b1, 1'b0, 0);
        wait_drain(20);
        chk("badpar_key_out", key_out, 32'd0);
        chk("badpar_key_valid", {31'd0, key_valid}, 32'd0);

        // Good frame, continuous strobes
        send_frame(32'hDEADBEEF, 1'b0, 1'b1, 0);
        wait_drain(20);
        do_ack(1);
        chk("key_after_ack", key_out, 32'hDEADBEEF);

        // Leading noise and 3-cycle gaps between strobes; ack held 2 cycles
        send_bit(1'b1, 3); send_bit(1'b1, 3); send_bit(1'b0, 3);
        send_frame(32'hCAFEF00D, 1'b0, 1'b1, 3);
        wait_drain(20);
        do_ack(2);

        // Timeout after 10 data bits, then a good frame
        send_sync(0);
        send_data(32'h0000_03FF, 10, 0);
        push(1'b1, 32'd0, last_cyc + 256);
        wait_drain(300);
        chk("timeout_key_out", key_out, 32'hCAFEF00D);
        send_frame(32'h12345678, 1'b1, 1'b1, 0);
        wait_drain(20);

        // Frame streamed while holding: ignored
        send_sync(0);
        send_data(32'h0F0F0F0F, 32, 0);
        send_bit(1'b0, 0);
        chk("hold_key_valid", {31'd0, key_valid}, 32'd1);
        chk("hold_key_out", key_out, 32'h12345678);
        do_ack(1);
        send_frame(32'h0F0F0F0F, 1'b0, 1'b1, 0);
        wait_drain(20);
        do_ack(1);

        // Reset during data bit 16
        send_sync(0);
        send_data(32'h5A5A5A5A, 16, 0);
        sin = 1'b1; sin_valid = 1'b1; rst = 1'b1;
        #1;
        chk("midrst_key_out", key_out, 32'd0);
        chk("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        @(negedge clk);
        send_frame(32'hA5A5A5A5, 1'b0, 1'b1, 0);
        wait_drain(20);
        chk("final_key_out", key_out, 32'hA5A5A5A5);
        do_ack(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
